// File: rtl/frame_consumer.sv
// Frame sink: stores one IMAGE_SIZE-pixel frame, keeps checksum and counters, readback port.
// Latency: frame_done/frame_count update 1 cycle after the last transfer; rd_data 1 cycle after rd_addr.
// Backpressure: ready_out low outside CAPTURE and one cycle in every throttle+1 capture cycles.
module frame_consumer #(
  parameter int IMAGE_SIZE = 1024,
  parameter int AW         = $clog2(IMAGE_SIZE)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    pixel_in,
  input  logic          valid_in,
  output logic          ready_out,
  input  logic          enable,
  input  logic [3:0]    throttle,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [15:0]   checksum,
  output logic [AW:0]   pixel_count,
  output logic          frame_done,
  output logic [7:0]    frame_count,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   pixel_count_q;
  logic [15:0]   checksum_q;
  logic [3:0]    tcnt_q;
  logic          frame_done_q;
  logic [7:0]    frame_count_q;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem [IMAGE_SIZE];

  logic xfer;
  logic last_xfer;
  logic start;

  // ready_out depends only on registered state, tcnt and throttle, so xfer has no loop through valid_in
  assign xfer      = valid_in && ready_out;
  assign last_xfer = xfer && (pixel_count_q == (AW+1)'(IMAGE_SIZE - 1));
  // entering CAPTURE from IDLE or DONE restarts the frame bookkeeping
  assign start     = (state_d == S_CAPTURE) && (state_q != S_CAPTURE);

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic; a completing transfer wins over enable going low
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (enable) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (last_xfer)    state_d = S_DONE;
        else if (!enable) state_d = S_IDLE;
      end
      S_DONE:    state_d = enable ? S_CAPTURE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // state-decoded outputs: ready pattern drops on the cycle tcnt reaches throttle
  always_comb begin
    ready_out = 1'b0;
    busy      = 1'b0;
    if (state_q == S_CAPTURE) begin
      busy      = 1'b1;
      ready_out = (throttle == 4'd0) || (tcnt_q != throttle);
    end
  end

  // frame bookkeeping: write pointer, counters, checksum and throttle phase
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q      <= '0;
      pixel_count_q <= '0;
      checksum_q    <= '0;
      tcnt_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= last_xfer;
      if (last_xfer) frame_count_q <= frame_count_q + 8'd1;
      if (start) begin
        wr_ptr_q      <= '0;
        pixel_count_q <= '0;
        checksum_q    <= '0;
        tcnt_q        <= '0;
      end else if (state_q == S_CAPTURE) begin
        // tcnt >= throttle also covers a throttle lowered below the current phase
        if ((throttle == 4'd0) || (tcnt_q >= throttle)) tcnt_q <= 4'd0;
        else                                             tcnt_q <= tcnt_q + 4'd1;
        if (xfer) begin
          wr_ptr_q      <= wr_ptr_q + AW'(1);
          pixel_count_q <= pixel_count_q + (AW+1)'(1);
          checksum_q    <= checksum_q + {8'h00, pixel_in};
        end
      end
    end
  end

  // frame buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr_q] <= pixel_in;
  end

  // registered readback; a same-cycle write to the same address returns the old byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_data_q <= 8'h00;
    else       rd_data_q <= mem[rd_addr];
  end

  assign rd_data     = rd_data_q;
  assign checksum    = checksum_q;
  assign pixel_count = pixel_count_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_consumer.sv
// Bench for frame_consumer: directed frames with random and patterned pixels against a frame-level model.
// Model: ready pattern from capture-cycle index modulo throttle+1, memory/checksum from the list of transfers.
// Inputs driven and outputs sampled on the falling edge.
module tb_frame_consumer;
  localparam int IMAGE_SIZE = 1024;
  localparam int AW         = 10;
  localparam int BUDGET     = 10000;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    pixel_in;
  logic          valid_in;
  logic          ready_out;
  logic          enable;
  logic [3:0]    throttle;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [15:0]   checksum;
  logic [AW:0]   pixel_count;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          busy;

  always #5 clk = ~clk;

  frame_consumer #(.IMAGE_SIZE(IMAGE_SIZE), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .pixel_in(pixel_in), .valid_in(valid_in),
    .ready_out(ready_out), .enable(enable), .throttle(throttle),
    .rd_addr(rd_addr), .rd_data(rd_data), .checksum(checksum),
    .pixel_count(pixel_count), .frame_done(frame_done),
    .frame_count(frame_count), .busy(busy)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] m_mem [IMAGE_SIZE];
  int         m_count  = 0;
  logic [15:0] m_sum   = 16'h0;
  int         m_frames = 0;
  bit         mem_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one capture from the current falling edge until n transfers have happened.
  // vmode 0: valid always, pixel = index; 1: valid on even cycles (A5), FF otherwise; 2: random.
  task automatic capture(input int n, input int thr, input int vmode, input bit drop_last, input string tag);
    int cyc;
    bit exp_rdy;
    bit v;
    logic [7:0] pix;
    logic [7:0] rb_exp;
    throttle = 4'(thr);
    enable   = 1'b1;
    m_count  = 0;
    m_sum    = 16'h0;
    cyc      = 0;
    rb_exp   = 8'h00;
    @(posedge clk);
    while (m_count < n) begin
      @(negedge clk);
      if (cyc >= BUDGET) begin
        chk({tag, "_budget"}, 32'(cyc), 32'(BUDGET - 1));
        break;
      end
      exp_rdy = (thr == 0) || ((cyc % (thr + 1)) != thr);
      chk({tag, "_ready"}, 32'(ready_out), 32'(exp_rdy));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
      chk({tag, "_pcount"}, 32'(pixel_count), 32'(m_count));
      if (mem_known && cyc > 0) chk({tag, "_rdwr"}, 32'(rd_data), 32'(rb_exp));
      rd_addr = AW'(m_count);
      rb_exp  = m_mem[m_count];
      case (vmode)
        0: begin v = 1'b1; pix = 8'(m_count); end
        1: begin v = (cyc % 2 == 0); pix = v ? 8'hA5 : 8'hFF; end
        default: begin v = ($urandom_range(0, 3) != 0); pix = 8'($urandom_range(0, 255)); end
      endcase
      valid_in = v;
      pixel_in = pix;
      if (v && exp_rdy) begin
        m_mem[m_count] = pix;
        m_sum = m_sum + 16'(pix);
        m_count++;
        if (drop_last && m_count == n) enable = 1'b0;
      end
      cyc++;
      @(posedge clk);
    end
    #1;
    valid_in = 1'b0;
  endtask

  // Checks the cycle after the last transfer: DONE for a full frame, IDLE for an abort.
  task automatic frame_end(input bit full, input string tag);
    @(negedge clk);
    if (full) begin
      m_frames  = (m_frames + 1) % 256;
      mem_known = 1'b1;
    end
    chk({tag, "_fdone"}, 32'(frame_done), 32'(full));
    chk({tag, "_ready"}, 32'(ready_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fcount"}, 32'(frame_count), 32'(m_frames));
    chk({tag, "_pcount"}, 32'(pixel_count), 32'(m_count));
    chk({tag, "_csum"}, 32'(checksum), 32'(m_sum));
  endtask

  // Reads the whole buffer back in IDLE and checks counters are held.
  task automatic sweep(input string tag);
    for (int a = 0; a <= IMAGE_SIZE; a++) begin
      @(negedge clk);
      if (a == 0) begin
        chk({tag, "_fdone_low"}, 32'(frame_done), 32'd0);
        chk({tag, "_idle_ready"}, 32'(ready_out), 32'd0);
      end
      if (a > 0) chk({tag, "_rd"}, 32'(rd_data), 32'(m_mem[a - 1]));
      if (a < IMAGE_SIZE) rd_addr = AW'(a);
    end
    chk({tag, "_hold_pcount"}, 32'(pixel_count), 32'(m_count));
    chk({tag, "_hold_csum"}, 32'(checksum), 32'(m_sum));
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; valid_in = 1'b0; pixel_in = 8'h00;
    throttle = 4'd0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_csum", 32'(checksum), 32'd0);
    chk("rst_pcount", 32'(pixel_count), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_fcount", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(ready_out), 32'd0);

    // ramp frame, no throttle
    capture(IMAGE_SIZE, 0, 0, 1'b1, "t1");
    frame_end(1'b1, "t1");
    chk("t1_csum_const", 32'(checksum), 32'h0000FE00);
    sweep("t1");
    @(negedge clk); rd_addr = AW'(300);
    @(negedge clk); chk("t1_rd300", 32'(rd_data), 32'h2C);

    // same frame with throttle 3
    capture(IMAGE_SIZE, 3, 0, 1'b1, "t2");
    frame_end(1'b1, "t2");
    chk("t2_csum_const", 32'(checksum), 32'h0000FE00);
    sweep("t2");

    // alternating valid
    capture(IMAGE_SIZE, 0, 1, 1'b1, "t3");
    frame_end(1'b1, "t3");
    chk("t3_csum_const", 32'(checksum), 32'h00009400);
    sweep("t3");

    // abort after 100 transfers, last one in the same cycle as enable low
    capture(100, $urandom_range(1, 15), 2, 1'b1, "t4");
    frame_end(1'b0, "t4");
    repeat (3) @(negedge clk);
    chk("t4_hold_ready", 32'(ready_out), 32'd0);
    chk("t4_hold_pcount", 32'(pixel_count), 32'd100);
    chk("t4_hold_fcount", 32'(frame_count), 32'(m_frames));

    // restart, then two back-to-back frames with enable held
    capture(IMAGE_SIZE, $urandom_range(0, 15), 2, 1'b0, "t5a");
    frame_end(1'b1, "t5a");
    capture(IMAGE_SIZE, $urandom_range(0, 15), 2, 1'b1, "t5b");
    frame_end(1'b1, "t5b");
    sweep("t5");

    // reset in the middle of a frame
    capture(500, 2, 2, 1'b0, "t6");
    #2 rstn = 1'b0;
    #1;
    m_frames = 0;
    chk("t6_rst_ready", 32'(ready_out), 32'd0);
    chk("t6_rst_rd", 32'(rd_data), 32'd0);
    chk("t6_rst_csum", 32'(checksum), 32'd0);
    chk("t6_rst_pcount", 32'(pixel_count), 32'd0);
    chk("t6_rst_fdone", 32'(frame_done), 32'd0);
    chk("t6_rst_fcount", 32'(frame_count), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    enable = 1'b0;
    rstn   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_idle_ready", 32'(ready_out), 32'd0);
      chk("t6_idle_busy", 32'(busy), 32'd0);
    end
    capture(IMAGE_SIZE, $urandom_range(0, 15), 2, 1'b1, "t7");
    frame_end(1'b1, "t7");
    sweep("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
